// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port unified memory between instruction fetch
// and the data stage. Data normally wins; a starvation counter forces an IF
// grant after STARVE_MAX data grants made while a fetch was waiting. A busy
// counter aborts an access that never sees mem_ack and flags bus_err.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_rd_req,
  input  logic        d_wr_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int BW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [BW-1:0] BUSY_LAST  = BW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

  state_t          state, stateNxt;
  logic [SW-1:0]   starveCnt;
  logic [BW-1:0]   busyCnt;

  logic dReq, ifPend, starveHit, ifWin, dGrant;
  logic busy, timedOut, finish;

  // A requester whose ready pulse is high this cycle is already served; its
  // still-high request must not launch a second access. Data keeps priority
  // even in its own ready cycle, so a back-to-back data requester leaves the
  // slot empty rather than handing it to IF -- only the starvation limit
  // lets IF in, which is what keeps starveCnt meaningful.
  assign dReq      = d_rd_req | d_wr_req;
  assign ifPend    = if_req & ~if_ready;
  assign starveHit = (starveCnt == STARVE_LIM);
  assign ifWin     = ifPend & (starveHit | ~dReq);
  assign dGrant    = dReq & ~d_ready & ~ifWin;

  assign busy      = (state != IDLE);
  assign timedOut  = busy & ~mem_ack & (busyCnt == BUSY_LAST);
  assign finish    = busy & (mem_ack | timedOut);

  assign mem_en    = busy;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dReq & ~d_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  // Next-state: requests only matter in IDLE; a busy state leaves on ack or timeout.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE: begin
        if (dGrant)     stateNxt = D_BUSY;
        else if (ifWin) stateNxt = IF_BUSY;
      end
      IF_BUSY, D_BUSY: begin
        if (finish) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Access registers, read-data capture, ready/error pulses and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= '0;
      busyCnt   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          busyCnt <= '0;
          if (dGrant) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_we    <= d_wr_req;
            if (ifPend && !starveHit) starveCnt <= starveCnt + 1'b1;
          end else if (ifWin) begin
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            starveCnt <= '0;
          end
        end
        IF_BUSY: begin
          if (finish) begin
            if_ready <= 1'b1;
            bus_err  <= timedOut;
            if (mem_ack) if_rdata <= mem_rdata;
          end else begin
            busyCnt <= busyCnt + 1'b1;
          end
        end
        D_BUSY: begin
          if (finish) begin
            d_ready <= 1'b1;
            bus_err <= timedOut;
            if (mem_ack && !mem_we) d_rdata <= mem_rdata;
          end else begin
            busyCnt <= busyCnt + 1'b1;
          end
        end
        default: busyCnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Stimulus pushes expected memory
// accesses and expected ready responses into queues; a memory responder and
// a ready monitor pop and compare independently of the stimulus thread.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_rd_req = 1'b0;
  logic        d_wr_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  mem_port_arbiter #(.STARVE_MAX(3), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;   // value the memory returns
    int          ackAt;   // busy cycle carrying mem_ack, 0 = never
    int          len;     // expected number of mem_en cycles
  } acc_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  acc_t accQ[$];
  rsp_t ifQ[$];
  rsp_t dQ[$];

  int nChecks = 0;
  int nFails  = 0;
  int dLeft   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    nChecks++;
    nFails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic acc_t mkAcc(logic [31:0] a, logic w, logic [31:0] wd,
                                 logic [31:0] rd, int ackAt, int len);
    acc_t x;
    x.addr = a; x.we = w; x.wdata = wd; x.rdata = rd; x.ackAt = ackAt; x.len = len;
    return x;
  endfunction

  function automatic rsp_t mkRsp(logic [31:0] d, logic e);
    rsp_t r;
    r.data = d; r.err = e;
    return r;
  endfunction

  // Memory model: checks each access against the expected queue, checks the
  // request stays stable, returns data and acks on the scheduled busy cycle.
  acc_t cur;
  bit   active = 0;
  int   cnt = 0;
  always @(posedge clk) begin
    #2;
    if (mem_en && !active) begin
      if (accQ.size() == 0) begin
        failNow("unexpected_access");
        cur = mkAcc(mem_addr, mem_we, mem_wdata, 32'h0, 1, 1);
      end else begin
        cur = accQ.pop_front();
        chk("acc_addr", mem_addr, cur.addr);
        chk("acc_we", {31'b0, mem_we}, {31'b0, cur.we});
        if (cur.we) chk("acc_wdata", mem_wdata, cur.wdata);
      end
      active = 1;
      cnt = 1;
    end else if (mem_en) begin
      cnt++;
      chk("acc_addr_stable", mem_addr, cur.addr);
      chk("acc_we_stable", {31'b0, mem_we}, {31'b0, cur.we});
    end else if (active) begin
      chk("busy_len", 32'(cnt), 32'(cur.len));
      active = 0;
    end
    mem_ack   = mem_en && (cnt == cur.ackAt);
    mem_rdata = cur.rdata;
  end

  // Ready/error monitor plus the combinational stall relations.
  always @(posedge clk) begin
    rsp_t e;
    #2;
    if (if_ready === 1'b1) begin
      if (ifQ.size() == 0) failNow("unexpected_if_ready");
      else begin
        e = ifQ.pop_front();
        chk("if_rdata", if_rdata, e.data);
        chk("if_bus_err", {31'b0, bus_err}, {31'b0, e.err});
      end
    end
    if (d_ready === 1'b1) begin
      if (dQ.size() == 0) failNow("unexpected_d_ready");
      else begin
        e = dQ.pop_front();
        chk("d_rdata", d_rdata, e.data);
        chk("d_bus_err", {31'b0, bus_err}, {31'b0, e.err});
      end
    end
    if (bus_err === 1'b1 && if_ready !== 1'b1 && d_ready !== 1'b1)
      failNow("bus_err_without_ready");
    chk("stall_if", {31'b0, stall_if}, {31'b0, if_req & ~if_ready});
    chk("stall_mem", {31'b0, stall_mem}, {31'b0, (d_rd_req | d_wr_req) & ~d_ready});
  end

  // Requester behaviour: drop requests on ready, or move on to the next store.
  task automatic run(input int budget, input string tag);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (if_ready) if_req = 1'b0;
      if (d_ready) begin
        if (dLeft > 1) begin
          dLeft--;
          d_addr  = d_addr + 32'd4;
          d_wdata = d_wdata + 32'd1;
        end else begin
          dLeft = 0;
          d_rd_req = 1'b0;
          d_wr_req = 1'b0;
        end
      end
      done = !if_req && !d_rd_req && !d_wr_req && !mem_en;
    end
    if (!done) failNow({tag, "_timeout"});
    chk({tag, "_acc_left"}, 32'(accQ.size()), 32'd0);
    chk({tag, "_rsp_left"}, 32'(ifQ.size() + dQ.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_readys", {30'b0, if_ready, d_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // IF-only fetch, minimum latency
    accQ.push_back(mkAcc(32'h40, 1'b0, 32'h0, 32'h8C020004, 1, 1));
    ifQ.push_back(mkRsp(32'h8C020004, 1'b0));
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    chk("t1_mem_en_c1", {31'b0, mem_en}, 32'd1);
    chk("t1_mem_addr_c1", mem_addr, 32'h40);
    chk("t1_if_ready_c1", {31'b0, if_ready}, 32'd0);
    @(negedge clk);
    chk("t1_if_ready_c2", {31'b0, if_ready}, 32'd1);
    chk("t1_if_rdata_c2", if_rdata, 32'h8C020004);
    chk("t1_mem_en_c2", {31'b0, mem_en}, 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    chk("t1_mem_en_c3", {31'b0, mem_en}, 32'd0);

    // Simultaneous IF and load at 0x100: data first, then IF
    accQ.push_back(mkAcc(32'h100, 1'b0, 32'h0, 32'h11111111, 3, 3));
    accQ.push_back(mkAcc(32'h100, 1'b0, 32'h0, 32'h22222222, 3, 3));
    dQ.push_back(mkRsp(32'h11111111, 1'b0));
    ifQ.push_back(mkRsp(32'h22222222, 1'b0));
    if_req = 1'b1; if_addr = 32'h100;
    d_rd_req = 1'b1; d_addr = 32'h100; dLeft = 1;
    @(negedge clk);
    chk("t2_stall_if_during_d", {31'b0, stall_if}, 32'd1);
    run(60, "t2");

    // Store with both request lines high: write, load data untouched
    accQ.push_back(mkAcc(32'h500, 1'b1, 32'hCAFEF00D, 32'h55555555, 2, 2));
    dQ.push_back(mkRsp(32'h11111111, 1'b0));
    d_rd_req = 1'b1; d_wr_req = 1'b1; d_addr = 32'h500; d_wdata = 32'hCAFEF00D; dLeft = 1;
    run(30, "t3");

    // Starvation: four back-to-back stores with a fetch waiting
    accQ.push_back(mkAcc(32'h600, 1'b1, 32'hA0, 32'hBAD00000, 1, 1));
    accQ.push_back(mkAcc(32'h604, 1'b1, 32'hA1, 32'hBAD00001, 1, 1));
    accQ.push_back(mkAcc(32'h608, 1'b1, 32'hA2, 32'hBAD00002, 1, 1));
    accQ.push_back(mkAcc(32'h300, 1'b0, 32'h0, 32'h33333333, 1, 1));
    accQ.push_back(mkAcc(32'h60C, 1'b1, 32'hA3, 32'hBAD00003, 1, 1));
    for (int i = 0; i < 4; i++) dQ.push_back(mkRsp(32'h11111111, 1'b0));
    ifQ.push_back(mkRsp(32'h33333333, 1'b0));
    if_req = 1'b1; if_addr = 32'h300;
    d_wr_req = 1'b1; d_addr = 32'h600; d_wdata = 32'hA0; dLeft = 4;
    run(100, "t4");
    chk("t4_starve_cnt", 32'(dut.starveCnt), 32'd0);

    // Timeout: load never acked
    accQ.push_back(mkAcc(32'h200, 1'b0, 32'h0, 32'h77777777, 0, 16));
    dQ.push_back(mkRsp(32'h11111111, 1'b1));
    d_rd_req = 1'b1; d_addr = 32'h200; dLeft = 1;
    run(40, "t5");

    // Reset in the second D_BUSY cycle
    accQ.push_back(mkAcc(32'h700, 1'b0, 32'h0, 32'h99999999, 0, 2));
    d_rd_req = 1'b1; d_addr = 32'h700; dLeft = 1;
    for (int i = 0; i < 10 && !mem_en; i++) @(negedge clk);
    if (!mem_en) failNow("t6_no_mem_en");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_mem_en", {31'b0, mem_en}, 32'd0);
    chk("t6_mem_we", {31'b0, mem_we}, 32'd0);
    chk("t6_mem_addr", mem_addr, 32'd0);
    chk("t6_mem_wdata", mem_wdata, 32'd0);
    chk("t6_if_rdata", if_rdata, 32'd0);
    chk("t6_d_rdata", d_rdata, 32'd0);
    chk("t6_pulses", {29'b0, if_ready, d_ready, bus_err}, 32'd0);
    chk("t6_stall_mem_in_rst", {31'b0, stall_mem}, 32'd1);
    d_rd_req = 1'b0; dLeft = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_acc_left", 32'(accQ.size()), 32'd0);

    // Recovery fetch after reset
    accQ.push_back(mkAcc(32'h80, 1'b0, 32'h0, 32'h44444444, 2, 2));
    ifQ.push_back(mkRsp(32'h44444444, 1'b0));
    if_req = 1'b1; if_addr = 32'h80;
    run(30, "t7");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Shares one single-port unified memory between instruction fetch (IF) and the data stage (MEM), and generates pipeline stalls.

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 3: maximum consecutive data grants while IF is waiting.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum busy cycles without mem_ack.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 if_req  in  1  fetch request; held high until if_ready.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_rdata  out  32  fetched word.
REQ-008 if_ready  out  1  one-cycle pulse; if_rdata valid.
REQ-009 d_rd_req / d_wr_req  in  1 each  load / store request; held until d_ready.
REQ-010 d_addr, d_wdata  in  32 each  data address and store data.
REQ-011 d_rdata  out  32  load data.
REQ-012 d_ready  out  1  one-cycle pulse; load or store complete.
REQ-013 mem_en, mem_we  out  1 each  memory strobe and write enable.
REQ-014 mem_addr, mem_wdata  out  32 each  registered address and write data.
REQ-015 mem_rdata  in  32  memory read data; mem_ack  in  1  access complete.
REQ-016 stall_if, stall_mem  out  1 each  freeze the front-end / back-end pipeline.
REQ-017 bus_err  out  1  one-cycle pulse on timeout.

Function
REQ-018 FSM states SHALL be IDLE, IF_BUSY and D_BUSY.
REQ-019 In IDLE with a data request pending and grant allowed, SHALL register d_addr, d_wdata and mem_we=d_wr_req, then enter D_BUSY.
REQ-020 Otherwise in IDLE with if_req pending, SHALL register if_addr with mem_we=0, then enter IF_BUSY.
REQ-021 Arbitration: data has priority, except when starve_cnt==STARVE_MAX and if_req is high; IF is then granted.
REQ-022 starve_cnt SHALL increment on each data grant made while if_req is high, saturating at STARVE_MAX.
REQ-023 starve_cnt SHALL clear on every IF grant.
REQ-024 mem_en SHALL be 1 exactly in the busy states; mem_addr, mem_wdata and mem_we SHALL be stable throughout a transaction.
REQ-025 On a busy-state cycle with mem_ack=1, the next edge SHALL:
  - capture mem_rdata into if_rdata (IF) or d_rdata (data load only);
  - pulse the matching ready signal for 1 cycle;
  - return to IDLE.
REQ-026 Minimum latency: request in cycle 0 -> mem_en in cycle 1 -> ack in cycle 1 -> ready in cycle 2.
REQ-027 In the cycle a ready pulse is high, the arbiter SHALL ignore that requester's request, so no duplicate access is issued.
REQ-028 d_rd_req and d_wr_req both high SHALL be treated as a store.
REQ-029 A store SHALL leave d_rdata unchanged.
REQ-030 A busy counter SHALL count cycles in a busy state.
REQ-031 If the busy counter reaches TIMEOUT with no ack, the arbiter SHALL:
  - return to IDLE;
  - pulse bus_err together with the matching ready signal;
  - leave the read data unchanged.
REQ-032 stall_if = if_req & ~if_ready, combinational.
REQ-033 stall_mem = (d_rd_req | d_wr_req) & ~d_ready, combinational.
REQ-034 mem_ack outside a busy state SHALL be ignored.
REQ-035 Requests SHALL be sampled only in IDLE; request changes during busy states have no effect.

Reset
REQ-036 On rst=1 at a clock edge, the arbiter SHALL:
  - enter IDLE;
  - clear starve_cnt and the busy counter;
  - drive all registered outputs to 0, including rdata, mem_addr and mem_wdata.
REQ-037 Reset asserted mid-transaction SHALL drop mem_en on the next edge and produce no ready or bus_err pulse.
REQ-038 stall outputs SHALL still follow REQ-032 and REQ-033 during reset.

Verification
REQ-039 IF-only fetch: if_req=1, if_addr=0x40, ack in cycle 1, mem_rdata=0x8C020004 -> mem_en in cycle 1 only; if_ready and if_rdata=0x8C020004 in cycle 2.
REQ-040 Simultaneous requests: if_req and d_rd_req at 0x100, ack after 3 cycles each -> data served first, then IF; stall_if high until IF completes.
REQ-041 Starvation: d_wr_req held through 4 back-to-back stores with if_req high -> after 3 data grants, IF is granted; starve_cnt returns to 0.
REQ-042 Timeout: d_rd_req with no mem_ack -> bus_err and d_ready pulse after 16 busy cycles; d_rdata unchanged; state returns to IDLE.
REQ-043 Reset mid-access: rst in the 2nd D_BUSY cycle -> mem_en=0 next cycle; no d_ready; all outputs 0.
REQ-044 Store semantics: d_rd_req and d_wr_req both high, d_wdata=0xCAFEF00D -> mem_we=1 and mem_wdata=0xCAFEF00D; d_rdata unchanged after ack.
